spi_flash_writer: RTL and testbench

- Write-side companion to the SPI flash word reader on the same flash pins: programs one 32-bit word, or erases one 4 KB sector, on a standard 24-bit-address SPI NOR flash.
- Issues WREN, then page program (0x02) or sector erase (0x20), then polls RDSR (0x05) until WIP clears.
- Sits between the bootloader/config logic and the flash pins. An external mux grants pin ownership; the reader and writer never drive the pins concurrently.

---
 rtl/spi_flash_pkg.sv | 44 ++++
 rtl/spi_byte_shift.sv | 55 +++++
 rtl/spi_flash_writer.sv | 153 +++++++++++++++
 tb/tb_spi_flash_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI NOR flash reader/writer pair: opcodes, status bits,
// writer state encoding and the latched write request.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE4K = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;

  localparam int unsigned STATUS_WIP_BIT  = 0;
  localparam logic [7:0]  STATUS_WIP_MASK = 8'(1 << STATUS_WIP_BIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WREN,
    ST_GAP1,
    ST_CMD,
    ST_GAP2,
    ST_POLL,
    ST_DONE
  } wr_state_t;

  typedef struct packed {
    logic        erase;
    logic [23:0] addr;
    logic [31:0] wdata;
  } wr_req_t;

  // Byte idx of the program/erase frame; data goes out least significant byte first.
  function automatic logic [7:0] cmd_byte(input wr_req_t req, input logic [2:0] idx);
    case (idx)
      3'd0:    cmd_byte = req.erase ? OP_SE4K : OP_PP;
      3'd1:    cmd_byte = req.addr[23:16];
      3'd2:    cmd_byte = req.addr[15:8];
      3'd3:    cmd_byte = req.addr[7:0];
      3'd4:    cmd_byte = req.wdata[7:0];
      3'd5:    cmd_byte = req.wdata[15:8];
      3'd6:    cmd_byte = req.wdata[23:16];
      default: cmd_byte = req.wdata[31:24];
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// Full-duplex mode-3 SPI byte engine: one setup clk then 8 bits of 2 clks, MSB first.
// A start on the done cycle chains the next byte with no idle clk (17 clk per byte).
module spi_byte_shift (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx,
  output logic       done_c
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST = CW'(16);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [7:0]    sh;

  assign done_c = busy && (cnt == LAST);

  // cnt 0 is setup; odd counts are the sclk-low half, even counts the sclk-high half
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      rx   <= '0;
      sclk <= 1'b1;
      mosi <= 1'b0;
    end else if (start && (!busy || done_c)) begin
      busy <= 1'b1;
      cnt  <= '0;
      sh   <= tx;
      sclk <= 1'b1;
    end else if (busy) begin
      if (done_c) begin
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
        if (!cnt[0]) begin
          sclk <= 1'b0;
          mosi <= sh[7];
          sh   <= {sh[6:0], 1'b0};
        end else begin
          sclk <= 1'b1;
          rx   <= {rx[6:0], miso};
        end
      end
    end
  end

endmodule

// File: rtl/spi_flash_writer.sv
// SPI NOR flash writer: WREN, then page program of one word or 4 KB sector erase,
// then RDSR polling until WIP clears or the poll budget runs out.
module spi_flash_writer
  import spi_flash_pkg::*;
#(
  parameter int unsigned CS_GAP     = 2,
  parameter int unsigned POLL_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        erase,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        error,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GW  = $clog2(CS_GAP + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(POLL_LIMIT);
  localparam logic [GW-1:0]  GAP_LAST = GW'(CS_GAP - 1);

  wr_state_t      state, state_n;
  wr_req_t        req;
  logic [2:0]     idx, idx_d;
  logic [PCW-1:0] poll_cnt, poll_d;
  logic [GW-1:0]  hi_cnt;
  logic           cs_d, ready_d, error_d, load;
  logic           sh_start, sh_done_c;
  logic [7:0]     sh_tx, sh_rx;
  logic           gap_ok, accept, last_cmd, wip, timeout;

  spi_byte_shift u_shift (
    .clk    (clk),
    .resetn (resetn),
    .start  (sh_start),
    .tx     (sh_tx),
    .miso   (spi_miso),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi),
    .rx     (sh_rx),
    .done_c (sh_done_c)
  );

  // hi_cnt is the number of completed CS-high clks minus one, saturating
  assign gap_ok   = (hi_cnt == GAP_LAST);
  assign accept   = valid && !ready && gap_ok;
  assign last_cmd = (idx == (req.erase ? 3'd3 : 3'd7));
  assign wip      = |(sh_rx & STATUS_WIP_MASK);
  assign timeout  = (poll_cnt == POLL_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) state_n = ST_WREN;
      ST_WREN: if (sh_done_c) state_n = ST_GAP1;
      ST_GAP1: if (gap_ok) state_n = ST_CMD;
      ST_CMD:  if (sh_done_c && last_cmd) state_n = ST_GAP2;
      ST_GAP2: if (gap_ok) state_n = ST_POLL;
      ST_POLL: if (sh_done_c && (idx != 3'd0) && (!wip || timeout)) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    cs_d     = spi_cs;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    load     = 1'b0;
    sh_start = 1'b0;
    sh_tx    = 8'h00;
    idx_d    = idx;
    poll_d   = poll_cnt;
    case (state)
      ST_IDLE: if (accept) begin
        load     = 1'b1;
        cs_d     = 1'b0;
        sh_start = 1'b1;
        sh_tx    = OP_WREN;
        poll_d   = '0;
      end
      ST_WREN: if (sh_done_c) cs_d = 1'b1;
      ST_GAP1: if (gap_ok) begin
        cs_d     = 1'b0;
        sh_start = 1'b1;
        sh_tx    = cmd_byte(req, 3'd0);
        idx_d    = 3'd0;
      end
      ST_CMD: if (sh_done_c) begin
        if (last_cmd) begin
          cs_d = 1'b1;
        end else begin
          sh_start = 1'b1;
          sh_tx    = cmd_byte(req, idx + 3'd1);
          idx_d    = idx + 3'd1;
        end
      end
      ST_GAP2: if (gap_ok) begin
        cs_d     = 1'b0;
        sh_start = 1'b1;
        sh_tx    = OP_RDSR;
        idx_d    = 3'd0;
      end
      // idx 0 is the RDSR opcode byte; every later byte is a status read
      ST_POLL: if (sh_done_c) begin
        if (idx == 3'd0) begin
          sh_start = 1'b1;
          idx_d    = 3'd1;
        end else if (!wip || timeout) begin
          cs_d    = 1'b1;
          ready_d = 1'b1;
          error_d = wip;
        end else begin
          sh_start = 1'b1;
          poll_d   = (poll_cnt == '1) ? poll_cnt : poll_cnt + PCW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      spi_cs   <= 1'b1;
      ready    <= 1'b0;
      error    <= 1'b0;
      idx      <= '0;
      poll_cnt <= '0;
      hi_cnt   <= '0;
      req      <= '0;
    end else begin
      spi_cs   <= cs_d;
      ready    <= ready_d;
      error    <= error_d;
      idx      <= idx_d;
      poll_cnt <= poll_d;
      hi_cnt   <= (cs_d && spi_cs) ? ((hi_cnt == GAP_LAST) ? hi_cnt : hi_cnt + GW'(1)) : '0;
      if (load) req <= '{erase: erase, addr: addr, wdata: wdata};
    end
  end

endmodule

// File: tb/tb_spi_flash_writer.sv
// Directed bench for spi_flash_writer with an SPI flash model and pin-level frame monitor.
module tb_spi_flash_writer;

  logic clk = 1'b0;
  logic resetn, valid_a, valid_b, erase, miso, sel;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic ready_a, error_a, cs_a, sclk_a, mosi_a;
  logic ready_b, error_b, cs_b, sclk_b, mosi_b;
  logic s_ready, s_error, s_cs, s_sclk, s_mosi;

  spi_flash_writer #(.CS_GAP(2), .POLL_LIMIT(65535)) dut_a (
    .clk(clk), .resetn(resetn), .valid(valid_a), .erase(erase), .addr(addr), .wdata(wdata),
    .ready(ready_a), .error(error_a), .spi_cs(cs_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a),
    .spi_miso(miso));

  spi_flash_writer #(.CS_GAP(2), .POLL_LIMIT(4)) dut_b (
    .clk(clk), .resetn(resetn), .valid(valid_b), .erase(erase), .addr(addr), .wdata(wdata),
    .ready(ready_b), .error(error_b), .spi_cs(cs_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b),
    .spi_miso(miso));

  assign s_ready = sel ? ready_b : ready_a;
  assign s_error = sel ? error_b : error_a;
  assign s_cs    = sel ? cs_b    : cs_a;
  assign s_sclk  = sel ? sclk_b  : sclk_a;
  assign s_mosi  = sel ? mosi_b  : mosi_a;

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // flash model / monitor state
  logic [7:0] fb [0:63][0:15];
  int nb [0:63];
  int flen [0:63];
  int gap [0:63];
  int fstart [0:63];
  int rdy_cyc [0:15];
  logic [7:0] sta [0:15];
  int nstat = 1;
  int nfr = 0, clen = 0, bcnt = 0, bitcnt = 0, hlen = 0, cyc = 0, wave_err = 0, rdy_cnt = 0;
  logic p_cs = 1'b1, p_sc = 1'b1, p_mo = 1'b0, p_rdy = 1'b0;
  logic [7:0] shr = 8'h00;
  logic [7:0] st;

  // Samples pins mid-cycle: captures MOSI on sclk rise, drives status on sclk fall.
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_cs !== p_cs && !(p_sc && s_sclk)) wave_err++;
      if (!p_cs && !s_cs && p_sc && s_sclk && s_mosi !== p_mo) wave_err++;
      if (s_ready === 1'b1) begin
        if (p_rdy || !s_cs) wave_err++;
        if (rdy_cnt < 16) rdy_cyc[rdy_cnt] = cyc;
        rdy_cnt++;
      end
      if (!p_cs && s_cs) begin
        if (nfr < 64) begin nb[nfr] = bcnt; flen[nfr] = clen; end
        if (bitcnt != 0) wave_err++;
        nfr++;
      end
      if (s_cs) hlen++;
      if (p_cs && !s_cs) begin
        if (nfr < 64) begin gap[nfr] = hlen; fstart[nfr] = cyc; end
        hlen = 0; clen = 0; bcnt = 0; bitcnt = 0;
      end
      if (!s_cs) begin
        clen++;
        if (!p_sc && s_sclk) begin
          shr = {shr[6:0], s_mosi};
          bitcnt++;
          if (bitcnt == 8) begin
            if (nfr < 64 && bcnt < 16) fb[nfr][bcnt] = shr;
            bcnt++;
            bitcnt = 0;
          end
        end
        if (p_sc && !s_sclk) begin
          miso = 1'b0;
          if (bcnt >= 1 && nfr < 64 && fb[nfr][0] == 8'h05) begin
            st = ((bcnt - 1) < nstat) ? sta[bcnt - 1] : sta[nstat - 1];
            miso = st[3'(7 - bitcnt)];
          end
        end
      end
      p_cs = s_cs; p_sc = s_sclk; p_mo = s_mosi; p_rdy = s_ready;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input int f, input int n, input logic [127:0] v);
    chk({tag, "_nbytes"}, 32'(nb[f]), 32'(n));
    chk({tag, "_clks"}, 32'(flen[f]), 32'(17 * n));
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(fb[f][i]), 32'(v[127 - 8 * i -: 8]));
  endtask

  task automatic run_op(input logic sl, input logic e, input logic [23:0] a, input logic [31:0] d,
                        input bit keep, output bit got, output logic err);
    got = 1'b0;
    err = 1'b0;
    sel = sl; erase = e; addr = a; wdata = d;
    if (sl) valid_b = 1'b1; else valid_a = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      if (s_ready === 1'b1) begin got = 1'b1; err = s_error; end
    end
    if (!keep) begin valid_a = 1'b0; valid_b = 1'b0; end
  endtask

  int f0, r0, w0;
  bit got, hit;
  logic err;

  initial begin
    resetn = 1'b0; valid_a = 1'b0; valid_b = 1'b0; erase = 1'b0;
    addr = '0; wdata = '0; sel = 1'b0; sta[0] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs_a), 32'(1));
    chk("rst_sclk", 32'(sclk_a), 32'(1));
    chk("rst_mosi", 32'(mosi_a), 32'(0));
    chk("rst_ready", 32'(ready_a), 32'(0));
    chk("rst_error", 32'(error_a), 32'(0));
    chk("rst_cs_b", 32'(cs_b), 32'(1));
    resetn = 1'b1;
    repeat (3) @(posedge clk);

    // program word, two busy status reads
    sta[0] = 8'h03; sta[1] = 8'h03; sta[2] = 8'h00; nstat = 3;
    f0 = nfr; r0 = rdy_cnt;
    run_op(1'b0, 1'b0, 24'h0AB0C0, 32'h12345678, 1'b0, got, err);
    repeat (4) @(posedge clk);
    chk("pp_ready", 32'(got), 32'(1));
    chk("pp_error", 32'(err), 32'(0));
    chk("pp_nready", 32'(rdy_cnt - r0), 32'(1));
    chk("pp_nframes", 32'(nfr - f0), 32'(3));
    chk_frame("pp_wren", f0, 1, {8'h06, 120'h0});
    chk_frame("pp_cmd", f0 + 1, 8, {64'h020AB0C078563412, 64'h0});
    chk_frame("pp_poll", f0 + 2, 4, {8'h05, 120'h0});
    chk("pp_gap1", 32'(gap[f0 + 1]), 32'(2));
    chk("pp_gap2", 32'(gap[f0 + 2]), 32'(2));

    // sector erase, ten busy reads
    for (int i = 0; i < 10; i++) sta[i] = 8'h01;
    sta[10] = 8'h00; nstat = 11;
    f0 = nfr; r0 = rdy_cnt;
    run_op(1'b0, 1'b1, 24'h123000, 32'h0, 1'b0, got, err);
    repeat (4) @(posedge clk);
    chk("se_ready", 32'(got), 32'(1));
    chk("se_error", 32'(err), 32'(0));
    chk("se_nready", 32'(rdy_cnt - r0), 32'(1));
    chk("se_nframes", 32'(nfr - f0), 32'(3));
    chk_frame("se_wren", f0, 1, {8'h06, 120'h0});
    chk_frame("se_cmd", f0 + 1, 4, {32'h20123000, 96'h0});
    chk_frame("se_poll", f0 + 2, 12, {8'h05, 120'h0});

    // poll timeout on the POLL_LIMIT=4 instance
    sta[0] = 8'h01; nstat = 1;
    f0 = nfr; r0 = rdy_cnt;
    run_op(1'b1, 1'b0, 24'h000100, 32'hDEADBEEF, 1'b0, got, err);
    repeat (4) @(posedge clk);
    chk("to_ready", 32'(got), 32'(1));
    chk("to_error", 32'(err), 32'(1));
    chk("to_nready", 32'(rdy_cnt - r0), 32'(1));
    chk("to_nframes", 32'(nfr - f0), 32'(3));
    chk_frame("to_cmd", f0 + 1, 8, {64'h02000100EFBEADDE, 64'h0});
    chk_frame("to_poll", f0 + 2, 6, {8'h05, 120'h0});
    chk("wave_rules_a", 32'(wave_err), 32'(0));
    sel = 1'b0;
    repeat (2) @(posedge clk);

    // reset during the third command byte
    f0 = nfr; erase = 1'b0; addr = 24'h0AB0C0; wdata = 32'hCAFEF00D; valid_a = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clk); #1;
      if (nfr == f0 + 1 && !s_cs && bcnt == 2 && bitcnt == 3) hit = 1'b1;
    end
    chk("mid_reached_cmd_b2", 32'(hit), 32'(1));
    resetn = 1'b0; valid_a = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cs", 32'(cs_a), 32'(1));
    chk("mid_rst_sclk", 32'(sclk_a), 32'(1));
    chk("mid_rst_ready", 32'(ready_a), 32'(0));
    chk("mid_rst_mosi", 32'(mosi_a), 32'(0));
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    f0 = nfr; r0 = rdy_cnt; w0 = wave_err;
    sta[0] = 8'h00; nstat = 1;
    run_op(1'b0, 1'b0, 24'h000010, 32'hA5A5A5A5, 1'b0, got, err);
    repeat (4) @(posedge clk);
    chk("post_ready", 32'(got), 32'(1));
    chk("post_error", 32'(err), 32'(0));
    chk("post_nframes", 32'(nfr - f0), 32'(3));
    chk_frame("post_wren", f0, 1, {8'h06, 120'h0});
    chk_frame("post_cmd", f0 + 1, 8, {64'h02000010A5A5A5A5, 64'h0});
    chk_frame("post_poll", f0 + 2, 2, {8'h05, 120'h0});

    // back-to-back: valid stays high across the first ready
    f0 = nfr; r0 = rdy_cnt;
    run_op(1'b0, 1'b0, 24'h000200, 32'h11223344, 1'b1, got, err);
    chk("b2b_first_ready", 32'(got), 32'(1));
    addr = 24'h000300; wdata = 32'h55667788;
    run_op(1'b0, 1'b0, 24'h000300, 32'h55667788, 1'b0, got, err);
    repeat (4) @(posedge clk);
    chk("b2b_second_ready", 32'(got), 32'(1));
    chk("b2b_nready", 32'(rdy_cnt - r0), 32'(2));
    chk("b2b_nframes", 32'(nfr - f0), 32'(6));
    chk_frame("b2b_cmd_a", f0 + 1, 8, {64'h0200020044332211, 64'h0});
    chk_frame("b2b_wren_b", f0 + 3, 1, {8'h06, 120'h0});
    chk_frame("b2b_cmd_b", f0 + 4, 8, {64'h0200030088776655, 64'h0});
    chk("b2b_start_after_ready", 32'(fstart[f0 + 3] > rdy_cyc[r0]), 32'(1));
    chk("b2b_gap", 32'(gap[f0 + 3] >= 2), 32'(1));
    chk("wave_rules_b", 32'(wave_err - w0), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
